// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini_cpu_mc core: opcodes, control states and
// instruction field helpers.
package mini_cpu_pkg;

  localparam int unsigned OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_JMP   = 3'd5,
    OP_JZ    = 3'd6,
    OP_HALT  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_e;

  // Opcode sits in the top OPW bits of a dw-bit word, passed zero-extended.
  function automatic op_e instr_op(input logic [31:0] w, input int unsigned dw);
    logic [31:0] t;
    t = w >> (dw - OPW);
    return op_e'(t[OPW-1:0]);
  endfunction

  function automatic logic writes_reg(input op_e op);
    return op inside {OP_LOAD, OP_ADD, OP_SUB};
  endfunction

endpackage

// File: rtl/mini_cpu_mc_if.sv
// Control, program-load and debug signals of mini_cpu_mc.
interface mini_cpu_mc_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned RW = 1,
  parameter int unsigned AW = 4
);
  logic                     run;
  logic                     prog_we;
  logic [AW-1:0]            prog_addr;
  logic [DW-1:0]            prog_data;
  logic [AW-1:0]            dbg_addr;
  logic [DW-1:0]            dbg_data;
  logic [AW-1:0]            pc;
  logic [(2**RW)*DW-1:0]    regs;
  logic                     zf;
  logic                     cf;
  logic                     busy;
  logic                     halted;

  modport master (
    output run, prog_we, prog_addr, prog_data, dbg_addr,
    input  dbg_data, pc, regs, zf, cf, busy, halted
  );

  modport slave (
    input  run, prog_we, prog_addr, prog_data, dbg_addr,
    output dbg_data, pc, regs, zf, cf, busy, halted
  );
endinterface

// File: rtl/mini_cpu_alu.sv
// Combinational ALU: LOAD passes b, ADD/SUB give DW-bit result plus carry/borrow.
module mini_cpu_alu
  import mini_cpu_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  op_e           op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] result_o,
  output logic          carry_o,
  output logic          zero_o
);
  logic [DW:0] wide;

  always_comb begin
    wide = {1'b0, a_i};
    case (op_i)
      OP_LOAD: wide = {1'b0, b_i};
      OP_ADD:  wide = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  wide = {1'b0, a_i} - {1'b0, b_i};
      default: wide = {1'b0, a_i};
    endcase
  end

  assign result_o = wide[DW-1:0];
  assign carry_o  = wide[DW];
  assign zero_o   = (wide[DW-1:0] == '0);
endmodule

// File: rtl/mini_cpu_mc.sv
// Multi-cycle accumulator core with unified memory, run/halt control,
// program-load and debug-read ports.
module mini_cpu_mc
  import mini_cpu_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned RW = 1,
  parameter int unsigned AW = 4
) (
  input logic          step,
  input logic          rst_n,
  mini_cpu_mc_if.slave cpu
);
  localparam int unsigned NREG  = 2**RW;
  localparam int unsigned DEPTH = 2**AW;

  if (DW != OPW + RW + AW) begin : g_cfg_check
    $error("mini_cpu_mc: DW must equal 3+RW+AW");
  end

  logic [DW-1:0]      mem [DEPTH];
  logic [DW-1:0]      regs_q [NREG];
  state_e             state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [DW-1:0]      ir_q, opnd_q;
  logic               zf_q, cf_q;

  op_e                op;
  logic [RW-1:0]      rsel;
  logic [AW-1:0]      addr;
  logic [DW-1:0]      alu_res;
  logic               alu_carry, alu_zero;
  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic [DW-1:0]      mem_wdata;
  logic [NREG*DW-1:0] regs_flat;
  logic               loadable;

  assign op       = instr_op(32'(ir_q), DW);
  assign rsel     = ir_q[DW-OPW-1 -: RW];
  assign addr     = ir_q[AW-1:0];
  assign loadable = (state_q == S_IDLE) || (state_q == S_HALT);

  mini_cpu_alu #(.DW(DW)) u_alu (
    .op_i     (op),
    .a_i      (regs_q[rsel]),
    .b_i      (opnd_q),
    .result_o (alu_res),
    .carry_o  (alu_carry),
    .zero_o   (alu_zero)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE:   if (cpu.run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (op == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = cpu.run ? S_FETCH : S_IDLE;
          if (op == OP_JMP || (op == OP_JZ && zf_q)) pc_d = addr;
          else                                      pc_d = pc_q + 1'b1;
        end
      end
      S_HALT: begin
        if (!cpu.run) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge step or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge step or negedge rst_n) begin
    if (!rst_n) begin
      ir_q   <= '0;
      opnd_q <= '0;
      zf_q   <= 1'b0;
      cf_q   <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH:  ir_q   <= mem[pc_q];
        S_DECODE: opnd_q <= mem[addr];
        S_EXEC: begin
          if (writes_reg(op)) begin
            regs_q[rsel] <= alu_res;
            zf_q         <= alu_zero;
          end
          if (op == OP_ADD || op == OP_SUB) cf_q <= alu_carry;
        end
        default: ;
      endcase
    end
  end

  // Memory is deliberately not reset; the write path is shared by STORE and program load.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cpu.prog_addr;
    mem_wdata = cpu.prog_data;
    if (state_q == S_EXEC) begin
      if (op == OP_STORE) begin
        mem_we    = 1'b1;
        mem_waddr = addr;
        mem_wdata = regs_q[rsel];
      end
    end else if (loadable && cpu.prog_we) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge step) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NREG; i++) regs_flat[i*DW +: DW] = regs_q[i];
  end

  assign cpu.dbg_data = mem[cpu.dbg_addr];
  assign cpu.pc       = pc_q;
  assign cpu.regs     = regs_flat;
  assign cpu.zf       = zf_q;
  assign cpu.cf       = cf_q;
  assign cpu.busy     = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign cpu.halted   = (state_q == S_HALT);
endmodule

// File: tb/tb_mini_cpu_mc.sv
// Directed bench for mini_cpu_mc: programs loaded via the port, results read via debug port.
module tb_mini_cpu_mc;
  logic step;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_fail;

  mini_cpu_mc_if #(.DW(8), .RW(1), .AW(4)) bus ();

  mini_cpu_mc #(.DW(8), .RW(1), .AW(4)) dut (
    .step  (step),
    .rst_n (rst_n),
    .cpu   (bus)
  );

  initial step = 1'b0;
  always #5 step = ~step;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge step);
      #1;
    end
  endtask

  task automatic prog(input logic [3:0] a, input logic [7:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    tick(1);
    bus.prog_we   = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [3:0] a, input logic [7:0] exp);
    bus.dbg_addr = a;
    #1;
    check(tag, 32'(bus.dbg_data), 32'(exp));
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.run       = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.dbg_addr  = '0;
    tick(2);
    rst_n = 1'b1;

    // 1: reset / idle
    check("rst_pc",     32'(bus.pc),     32'h0);
    check("rst_regs",   32'(bus.regs),   32'h0);
    check("rst_zf",     32'(bus.zf),     32'h0);
    check("rst_cf",     32'(bus.cf),     32'h0);
    check("rst_busy",   32'(bus.busy),   32'h0);
    check("rst_halted", 32'(bus.halted), 32'h0);
    tick(10);
    check("idle_pc",    32'(bus.pc),     32'h0);
    check("idle_busy",  32'(bus.busy),   32'h0);

    // 2: LOAD r0,[8]; HALT
    prog(4'd0, 8'h28);
    prog(4'd1, 8'hE0);
    prog(4'd8, 8'h05);
    peek("load_m8", 4'd8, 8'h05);
    bus.run = 1'b1;
    tick(1);
    check("fetch_busy", 32'(bus.busy), 32'h1);
    tick(3);
    check("ld_eax",     32'(bus.regs[7:0]), 32'h05);
    check("ld_zf",      32'(bus.zf),        32'h0);
    tick(3);
    check("ld_halted",  32'(bus.halted),    32'h1);
    check("ld_pc",      32'(bus.pc),        32'h1);
    check("ld_busy",    32'(bus.busy),      32'h0);
    bus.run = 1'b0;
    tick(1);
    check("unhalt_pc",     32'(bus.pc),     32'h0);
    check("unhalt_halted", 32'(bus.halted), 32'h0);

    // 3: ADD with carry, then SUB to zero
    prog(4'd0, 8'h2A);
    prog(4'd1, 8'h69);
    prog(4'd2, 8'hE0);
    prog(4'd9, 8'h20);
    prog(4'd10, 8'hF0);
    bus.run = 1'b1;
    tick(4);
    check("ld2_eax", 32'(bus.regs[7:0]), 32'hF0);
    tick(3);
    check("add_eax", 32'(bus.regs[7:0]), 32'h10);
    check("add_cf",  32'(bus.cf),        32'h1);
    check("add_zf",  32'(bus.zf),        32'h0);
    tick(3);
    check("add_halt_pc", 32'(bus.pc), 32'h2);
    prog(4'd9, 8'h10);
    peek("halt_prog_m9", 4'd9, 8'h10);
    prog(4'd0, 8'h00);
    prog(4'd1, 8'h89);
    bus.run = 1'b0;
    tick(1);
    bus.run = 1'b1;
    tick(7);
    check("sub_eax", 32'(bus.regs[7:0]), 32'h00);
    check("sub_zf",  32'(bus.zf),        32'h1);
    check("sub_cf",  32'(bus.cf),        32'h0);
    tick(3);
    check("sub_halted", 32'(bus.halted), 32'h1);

    // 4: JZ taken, LOAD ebx, JZ not taken, STORE r1,[15]
    bus.run = 1'b0;
    tick(1);
    prog(4'd0, 8'hC4);
    prog(4'd1, 8'hE0);
    prog(4'd4, 8'h3C);
    prog(4'd5, 8'hC1);
    prog(4'd6, 8'h5F);
    prog(4'd7, 8'hE0);
    prog(4'd12, 8'hA5);
    bus.run = 1'b1;
    tick(4);
    check("jz_taken_pc", 32'(bus.pc), 32'h4);
    tick(3);
    check("ld_ebx",    32'(bus.regs[15:8]), 32'hA5);
    check("ld_ebx_zf", 32'(bus.zf),         32'h0);
    check("ld_ebx_eax", 32'(bus.regs[7:0]), 32'h00);
    tick(3);
    check("jz_not_pc", 32'(bus.pc), 32'h6);
    tick(3);
    check("st_pc", 32'(bus.pc), 32'h7);
    peek("st_m15", 4'd15, 8'hA5);
    tick(3);
    check("st_halted", 32'(bus.halted), 32'h1);
    check("st_halt_pc", 32'(bus.pc),    32'h7);

    // 4/5: JMP 15 loop wraps, prog_we while busy, run dropped mid-instruction
    bus.run = 1'b0;
    tick(1);
    prog(4'd0, 8'hAF);
    prog(4'd15, 8'h00);
    bus.run = 1'b1;
    tick(4);
    check("jmp_pc", 32'(bus.pc), 32'hF);
    tick(3);
    check("wrap_pc", 32'(bus.pc), 32'h0);
    bus.run       = 1'b0;
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'd12;
    bus.prog_data = 8'h33;
    tick(1);
    bus.prog_we   = 1'b0;
    tick(2);
    peek("busy_we_m12", 4'd12, 8'hA5);
    check("stop_pc",     32'(bus.pc),     32'hF);
    check("stop_busy",   32'(bus.busy),   32'h0);
    check("stop_halted", 32'(bus.halted), 32'h0);

    // 6: reset during EXEC of STORE r1,[13]
    prog(4'd0, 8'h5D);
    prog(4'd13, 8'h77);
    bus.run = 1'b1;
    tick(4);
    check("pre_rst_pc", 32'(bus.pc), 32'h0);
    tick(2);
    check("in_exec_busy", 32'(bus.busy), 32'h1);
    rst_n   = 1'b0;
    bus.run = 1'b0;
    #2;
    check("arst_busy", 32'(bus.busy), 32'h0);
    check("arst_pc",   32'(bus.pc),   32'h0);
    check("arst_regs", 32'(bus.regs), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("post_rst_busy",   32'(bus.busy),   32'h0);
    check("post_rst_halted", 32'(bus.halted), 32'h0);
    peek("abort_m13",  4'd13, 8'h77);
    peek("keep_m0",    4'd0,  8'h5D);
    peek("keep_m12",   4'd12, 8'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
